// File: rtl/sram_pkg.sv
// Shared state type and latency helper for the single-port SRAM model family.
// Imported by the storage core and the top-level control wrapper.
package sram_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sram_state_e;

    // Edges from a read request to Q/QVLD, given the OUT_REG setting.
    function automatic int unsigned SRAM_RD_LAT(input int unsigned out_reg);
        return (out_reg != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/sram_1p_core.sv
// Storage array with per-bit masked write and a registered read port.
// Out-of-range writes are dropped and out-of-range reads return zero; no control logic.
module sram_1p_core
    import sram_pkg::*;
#(
    parameter int unsigned BITS       = 32,
    parameter int unsigned WORD_DEPTH = 64,
    parameter int unsigned ADD_WIDTH  = 6
) (
    input  logic                 clk_i,
    input  logic                 clr_i,
    input  logic                 wr_i,
    input  logic                 rd_i,
    input  logic [ADD_WIDTH-1:0] addr_i,
    input  logic [BITS-1:0]      wdata_i,
    input  logic [BITS-1:0]      wmask_i,
    output logic [BITS-1:0]      rdata_o
);

    logic [BITS-1:0] mem_q [WORD_DEPTH];
    logic [BITS-1:0] rdata_q;
    logic [BITS-1:0] wword_d;
    logic            in_range;

    assign in_range = (32'(addr_i) < WORD_DEPTH);

    always_comb begin
        wword_d = '0;
        if (in_range) begin
            wword_d = (mem_q[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_i && in_range) begin
            mem_q[addr_i] <= wword_d;
        end
    end

    // Only the read register is cleared; array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            rdata_q <= '0;
        end else if (rd_i) begin
            rdata_q <= in_range ? mem_q[addr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_1p_bwe_init.sv
// Single-port SRAM model: post-reset init sweep with READY, bit-masked writes,
// optional output register and a one-cycle QVLD strobe per completed read.
module sram_1p_bwe_init
    import sram_pkg::*;
#(
    parameter int unsigned     BITS       = 32,
    parameter int unsigned     WORD_DEPTH = 64,
    parameter int unsigned     ADD_WIDTH  = ($clog2(WORD_DEPTH) < 1) ? 1 : $clog2(WORD_DEPTH),
    parameter int unsigned     OUT_REG    = 0,
    parameter logic [BITS-1:0] INIT_VAL   = '0
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 CEB,
    input  logic                 WEB,
    input  logic [BITS-1:0]      BWEB,
    input  logic [ADD_WIDTH-1:0] A,
    input  logic [BITS-1:0]      D,
    output logic [BITS-1:0]      Q,
    output logic                 QVLD,
    output logic                 READY
);

    localparam int unsigned          RD_LAT    = SRAM_RD_LAT(OUT_REG);
    localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(WORD_DEPTH - 1);

    sram_state_e          state_q;
    logic [ADD_WIDTH-1:0] cnt_q;
    logic [ADD_WIDTH-1:0] cnt_d;
    logic                 ready_q;

    logic                 user_rd;
    logic                 user_wr;
    logic                 core_wr;
    logic                 core_rd;
    logic [ADD_WIDTH-1:0] core_addr;
    logic [BITS-1:0]      core_wdata;
    logic [BITS-1:0]      core_wmask;
    logic [BITS-1:0]      core_rdata;
    logic                 rd_vld_q;

    // Equality tests leave an unknown CEB/WEB as an idle cycle in simulation.
    always_comb begin
        user_rd = 1'b0;
        user_wr = 1'b0;
        if (RSTB && (state_q == ST_RUN) && (CEB == 1'b0)) begin
            if (WEB == 1'b1) begin
                user_rd = 1'b1;
            end else if (WEB == 1'b0) begin
                user_wr = 1'b1;
            end
        end
    end

    always_comb begin
        core_wr    = user_wr;
        core_rd    = user_rd;
        core_addr  = A;
        core_wdata = D;
        core_wmask = ~BWEB;
        if (state_q == ST_INIT) begin
            core_wr    = RSTB;
            core_rd    = 1'b0;
            core_addr  = cnt_q;
            core_wdata = INIT_VAL;
            core_wmask = '1;
        end
    end

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign READY = ready_q;

    sram_1p_core #(
        .BITS       (BITS),
        .WORD_DEPTH (WORD_DEPTH),
        .ADD_WIDTH  (ADD_WIDTH)
    ) u_core (
        .clk_i   (CLK),
        .clr_i   (~RSTB),
        .wr_i    (core_wr),
        .rd_i    (core_rd),
        .addr_i  (core_addr),
        .wdata_i (core_wdata),
        .wmask_i (core_wmask),
        .rdata_o (core_rdata)
    );

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= user_rd;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_out_reg
            logic [BITS-1:0] q_q;
            logic            qvld_q;

            always_ff @(posedge CLK) begin
                if (!RSTB) begin
                    q_q    <= '0;
                    qvld_q <= 1'b0;
                end else begin
                    qvld_q <= rd_vld_q;
                    if (rd_vld_q) begin
                        q_q <= core_rdata;
                    end
                end
            end

            assign Q    = q_q;
            assign QVLD = qvld_q;
        end else begin : g_no_out_reg
            assign Q    = core_rdata;
            assign QVLD = rd_vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_sram_1p_bwe_init.sv
// Scoreboard bench: dut0 is 64 words with output register, dut1 is 48 words without.
// Reads push expected word and due cycle; a negedge monitor pops on each QVLD.
module tb_sram_1p_bwe_init;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstb = 1'b0;
    logic [1:0]       ceb;
    logic [1:0]       web;
    logic [1:0][31:0] bweb;
    logic [1:0][5:0]  a;
    logic [1:0][31:0] d;
    logic [1:0][31:0] q;
    logic [1:0]       qvld;
    logic [1:0]       ready;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_1p_bwe_init #(
        .BITS       (32),
        .WORD_DEPTH (64),
        .OUT_REG    (1)
    ) dut0 (
        .CLK (clk), .RSTB (rstb), .CEB (ceb[0]), .WEB (web[0]), .BWEB (bweb[0]),
        .A (a[0]), .D (d[0]), .Q (q[0]), .QVLD (qvld[0]), .READY (ready[0])
    );

    sram_1p_bwe_init #(
        .BITS       (32),
        .WORD_DEPTH (48),
        .OUT_REG    (0)
    ) dut1 (
        .CLK (clk), .RSTB (rstb), .CEB (ceb[1]), .WEB (web[1]), .BWEB (bweb[1]),
        .A (a[1]), .D (d[1]), .Q (q[1]), .QVLD (qvld[1]), .READY (ready[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_check(input int k);
        exp_t e;
        int   n;
        n = (k == 0) ? sb0.size() : sb1.size();
        total++;
        if (n == 0) begin
            bad++;
            $display("FAIL qvld_unexpected dut%0d: got qvld=1 q=%h want no pulse (cycle %0d)", k, q[k], cyc);
        end else begin
            if (k == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            if (q[k] !== e.data || cyc != e.due) begin
                bad++;
                $display("FAIL read dut%0d: got q=%h at cycle %0d want %h at cycle %0d",
                         k, q[k], cyc, e.data, e.due);
            end
        end
    endtask

    task automatic overdue(input int k);
        exp_t e;
        int   n;
        n = (k == 0) ? sb0.size() : sb1.size();
        if (n != 0) begin
            e = (k == 0) ? sb0[0] : sb1[0];
            if (e.due < cyc) begin
                total++;
                bad++;
                $display("FAIL qvld_missing dut%0d: got no pulse want q=%h at cycle %0d", k, e.data, e.due);
                if (k == 0) void'(sb0.pop_front());
                else        void'(sb1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (qvld[0] === 1'b1) pop_check(0); else overdue(0);
        if (qvld[1] === 1'b1) pop_check(1); else overdue(1);
    end

    task automatic idle(input int k);
        ceb[k]  = 1'b1;
        web[k]  = 1'b1;
        bweb[k] = '1;
        a[k]    = '0;
        d[k]    = '0;
    endtask

    task automatic wr(input int k, input logic [5:0] addr, input logic [31:0] data,
                      input logic [31:0] mask_n);
        ceb[k]  = 1'b0;
        web[k]  = 1'b0;
        a[k]    = addr;
        d[k]    = data;
        bweb[k] = mask_n;
        @(negedge clk);
        idle(k);
    endtask

    task automatic rd(input int k, input logic [5:0] addr, input logic [31:0] exp);
        exp_t e;
        ceb[k]  = 1'b0;
        web[k]  = 1'b1;
        a[k]    = addr;
        bweb[k] = '1;
        e.data  = exp;
        e.due   = cyc + ((k == 0) ? 2 : 1);
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        @(negedge clk);
        idle(k);
    endtask

    // Called on a negedge right after RSTB goes high; counts edges until READY.
    task automatic measure_ready(input int exp0, input int exp1);
        int r0;
        int r1;
        r0 = 0;
        r1 = 0;
        for (int n = 1; n <= 200 && (r0 == 0 || r1 == 0); n++) begin
            @(posedge clk);
            #1;
            if (r0 == 0 && ready[0] === 1'b1) r0 = n;
            if (r1 == 0 && ready[1] === 1'b1) r1 = n;
        end
        chk("ready_edges_dut0", r0, exp0);
        chk("ready_edges_dut1", r1, exp1);
        @(negedge clk);
    endtask

    initial begin
        idle(0);
        idle(1);
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_q_dut0", q[0], 32'h0);
        chk("rst_qvld_dut0", {31'b0, qvld[0]}, 32'h0);
        chk("rst_ready_dut0", {31'b0, ready[0]}, 32'h0);
        chk("rst_q_dut1", q[1], 32'h0);
        chk("rst_ready_dut1", {31'b0, ready[1]}, 32'h0);

        // init sweep timing, then swept contents
        rstb = 1'b1;
        measure_ready(64, 48);
        rd(0, 6'd0, 32'h0);
        rd(0, 6'd31, 32'h0);
        rd(0, 6'd63, 32'h0);
        rd(1, 6'd0, 32'h0);
        rd(1, 6'd47, 32'h0);

        // full write then read-after-write
        wr(0, 6'd5, 32'hDEAD_BEEF, 32'h0);
        rd(0, 6'd5, 32'hDEAD_BEEF);
        wr(1, 6'd5, 32'h1234_5678, 32'h0);
        rd(1, 6'd5, 32'h1234_5678);

        // bit-masked write: only the low half is written
        wr(0, 6'd7, 32'hFFFF_FFFF, 32'h0);
        wr(0, 6'd7, 32'h0, 32'hFFFF_0000);
        rd(0, 6'd7, 32'hFFFF_0000);
        wr(1, 6'd9, 32'h0000_0000, 32'h0);
        wr(1, 6'd9, 32'hABCD_EF01, 32'h0000_FFFF);
        rd(1, 6'd9, 32'hABCD_0000);

        // back-to-back burst
        for (int i = 0; i < 10; i++) wr(0, 6'(i), 32'hA5A5_0000 | 32'(i * 17), 32'h0);
        for (int i = 0; i < 10; i++) rd(0, 6'(i), 32'hA5A5_0000 | 32'(i * 17));
        repeat (4) @(negedge clk);
        chk("hold_q_dut0", q[0], 32'hA5A5_0099);
        chk("hold_qvld_dut0", {31'b0, qvld[0]}, 32'h0);

        // read in flight on dut0 and read coincident with reset on dut1: both dropped
        ceb[0] = 1'b0; web[0] = 1'b1; a[0] = 6'd5;
        @(negedge clk);
        idle(0);
        rstb = 1'b0;
        ceb[1] = 1'b0; web[1] = 1'b1; a[1] = 6'd5;
        @(negedge clk);
        idle(1);
        chk("rst_clears_q_dut0", q[0], 32'h0);
        chk("rst_clears_qvld_dut0", {31'b0, qvld[0]}, 32'h0);
        rstb = 1'b1;
        measure_ready(64, 48);

        // reset mid-sweep at cnt = 20 restarts from address 0
        wr(0, 6'd3, 32'h5555_AAAA, 32'h0);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        repeat (20) @(negedge clk);
        chk("midsweep_ready_dut0", {31'b0, ready[0]}, 32'h0);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        measure_ready(64, 48);
        rd(0, 6'd3, 32'h0);
        rd(0, 6'd7, 32'h0);
        rd(1, 6'd9, 32'h0);

        // out-of-range on the 48-word instance
        wr(1, 6'd47, 32'hCAFE_F00D, 32'h0);
        wr(1, 6'd50, 32'h1357_9BDF, 32'h0);
        rd(1, 6'd50, 32'h0);
        rd(1, 6'd47, 32'hCAFE_F00D);
        rd(1, 6'd2, 32'h0);
        rd(1, 6'd63, 32'h0);

        repeat (5) @(negedge clk);
        chk("sb0_drained", sb0.size(), 32'h0);
        chk("sb1_drained", sb1.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
